// File: rtl/dma_chbuf.sv
// dma_chbuf: DMA channel buffer. A source FIFO carries bus beats to the
// processing module, a destination FIFO carries module output back to the
// bus. Both FIFOs are first-word-fall-through and store a last tag per beat.

// Single FWFT FIFO with a last-tag bit packed as the MSB of each entry.
module dma_chbuf_fifo #(
    parameter int DW = 64,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr,
    input  logic [DW:0]   wdat,
    input  logic          rd,
    output logic [DW:0]   head,
    output logic [AW:0]   cnt,
    output logic          wr_ok,
    output logic          rd_ok
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // A read on empty is dropped even when a write lands the same cycle;
    // a write on full is only taken when a read frees the slot this cycle.
    assign rd_ok = rd && (cnt != '0);
    assign wr_ok = wr && ((cnt != FULL_C) || rd_ok);
    assign head  = mem[rptr];

    // Pointer and occupancy update; clr wins over any same-cycle traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array, left unreset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem[wptr] <= wdat;
    end
endmodule

// Channel buffer top: two FIFOs plus bus handshake flags, frame tracking,
// saturating output-beat counter and sticky error flags.
module dma_chbuf #(
    parameter int DW         = 64,
    parameter int AW         = 9,
    parameter int AE_TH      = 2,
    parameter int AF_TH      = 2,
    parameter int CW         = 16,
    parameter int FRAME_MODE = 0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          m_reset,
    input  logic          ss_xfer0,
    input  logic          ss_last0,
    input  logic [DW-1:0] wbs_dat_o0,
    output logic          ss_start0,
    output logic          ss_stop0,
    input  logic          m_src_getn,
    output logic [DW-1:0] m_src,
    output logic          m_src_last,
    output logic          m_src_empty,
    output logic          m_src_almost_empty,
    input  logic          m_dst_putn,
    input  logic [DW-1:0] m_dst,
    input  logic          m_dst_last,
    output logic          m_dst_full,
    output logic          m_dst_almost_full,
    input  logic          m_endn,
    input  logic          ss_xfer1,
    output logic [DW-1:0] wbs_dat_i1,
    output logic          ss_start1,
    output logic          ss_stop1,
    output logic          ss_end1,
    output logic [CW-1:0] ocnt,
    output logic          err_ovf,
    output logic          err_udf
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] HALF_C = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0] AE_C   = (AW+1)'(AE_TH);
    localparam logic [AW:0] AF_C   = (AW+1)'(DEPTH - AF_TH);

    logic [DW:0] src_head, dst_head;
    logic [AW:0] src_cnt, dst_cnt;
    logic        src_wr_ok, src_rd_ok, dst_wr_ok, dst_rd_ok;
    logic        src_rd, dst_wr;
    logic        src_empty, dst_empty;
    logic [AW:0] frames;

    assign src_rd = !m_src_getn;
    assign dst_wr = !m_dst_putn;

    dma_chbuf_fifo #(.DW(DW), .AW(AW)) u_src (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .clr   (m_reset),
        .wr    (ss_xfer0),
        .wdat  ({ss_last0, wbs_dat_o0}),
        .rd    (src_rd),
        .head  (src_head),
        .cnt   (src_cnt),
        .wr_ok (src_wr_ok),
        .rd_ok (src_rd_ok)
    );

    dma_chbuf_fifo #(.DW(DW), .AW(AW)) u_dst (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .clr   (m_reset),
        .wr    (dst_wr),
        .wdat  ({m_dst_last, m_dst}),
        .rd    (ss_xfer1),
        .head  (dst_head),
        .cnt   (dst_cnt),
        .wr_ok (dst_wr_ok),
        .rd_ok (dst_rd_ok)
    );

    assign src_empty = (src_cnt == '0);
    assign dst_empty = (dst_cnt == '0);

    // Source side flags; last tag gated so it reads 0 while empty.
    assign m_src              = src_head[DW-1:0];
    assign m_src_last         = !src_empty && src_head[DW];
    assign m_src_empty        = src_empty;
    assign m_src_almost_empty = (src_cnt <= AE_C);
    assign ss_start0          = (src_cnt < HALF_C);
    assign ss_stop0           = (src_cnt >= AF_C);

    // Destination side flags.
    assign wbs_dat_i1        = dst_head[DW-1:0];
    assign ss_end1           = !dst_empty && dst_head[DW];
    assign m_dst_full        = (dst_cnt == FULL_C);
    assign m_dst_almost_full = (dst_cnt >= AF_C);
    assign ss_stop1          = (dst_cnt <= AE_C);
    assign ss_start1         = (dst_cnt >= HALF_C)
                             || (!m_endn && !dst_empty)
                             || ((FRAME_MODE != 0) && (frames != '0));

    // Complete frames resident in dst: +1 per accepted last push, -1 per last pop.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            frames <= '0;
        end else if (m_reset) begin
            frames <= '0;
        end else begin
            case ({dst_wr_ok && m_dst_last, dst_rd_ok && dst_head[DW]})
                2'b10:   frames <= frames + 1'b1;
                2'b01:   frames <= frames - 1'b1;
                default: frames <= frames;
            endcase
        end
    end

    // Saturating count of accepted non-last dst beats.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ocnt <= '0;
        end else if (m_reset) begin
            ocnt <= '0;
        end else if (dst_wr_ok && !m_dst_last && (ocnt != '1)) begin
            ocnt <= ocnt + 1'b1;
        end
    end

    // Sticky error flags for rejected writes/reads on either FIFO.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (m_reset) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            err_ovf <= err_ovf || (ss_xfer0 && !src_wr_ok) || (dst_wr && !dst_wr_ok);
            err_udf <= err_udf || (src_rd && !src_rd_ok) || (ss_xfer1 && !dst_rd_ok);
        end
    end
endmodule

// File: tb/tb_dma_chbuf.sv
// Directed bench for dma_chbuf (DEPTH=16, CW=4, frame mode on) with
// queue scoreboards for both FIFOs.
module tb_dma_chbuf;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n_i = 1'b0;
    logic          m_reset = 1'b0;
    logic          ss_xfer0 = 1'b0;
    logic          ss_last0 = 1'b0;
    logic [DW-1:0] wbs_dat_o0 = '0;
    logic          ss_start0, ss_stop0;
    logic          m_src_getn = 1'b1;
    logic [DW-1:0] m_src;
    logic          m_src_last, m_src_empty, m_src_almost_empty;
    logic          m_dst_putn = 1'b1;
    logic [DW-1:0] m_dst = '0;
    logic          m_dst_last = 1'b0;
    logic          m_dst_full, m_dst_almost_full;
    logic          m_endn = 1'b1;
    logic          ss_xfer1 = 1'b0;
    logic [DW-1:0] wbs_dat_i1;
    logic          ss_start1, ss_stop1, ss_end1;
    logic [CW-1:0] ocnt;
    logic          err_ovf, err_udf;

    int total = 0;
    int bad = 0;
    logic [DW:0] sq[$];
    logic [DW:0] dq[$];
    logic [DW:0] e;

    dma_chbuf #(.DW(DW), .AW(AW), .AE_TH(2), .AF_TH(2), .CW(CW), .FRAME_MODE(1)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .m_reset(m_reset),
        .ss_xfer0(ss_xfer0), .ss_last0(ss_last0), .wbs_dat_o0(wbs_dat_o0),
        .ss_start0(ss_start0), .ss_stop0(ss_stop0),
        .m_src_getn(m_src_getn), .m_src(m_src), .m_src_last(m_src_last),
        .m_src_empty(m_src_empty), .m_src_almost_empty(m_src_almost_empty),
        .m_dst_putn(m_dst_putn), .m_dst(m_dst), .m_dst_last(m_dst_last),
        .m_dst_full(m_dst_full), .m_dst_almost_full(m_dst_almost_full),
        .m_endn(m_endn), .ss_xfer1(ss_xfer1), .wbs_dat_i1(wbs_dat_i1),
        .ss_start1(ss_start1), .ss_stop1(ss_stop1), .ss_end1(ss_end1),
        .ocnt(ocnt), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle();
        ss_xfer0 = 1'b0; ss_last0 = 1'b0; m_src_getn = 1'b1;
        m_dst_putn = 1'b1; m_dst_last = 1'b0; ss_xfer1 = 1'b0;
        m_endn = 1'b1; m_reset = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".flags"},
            {m_src_empty, m_src_almost_empty, ss_stop1, ss_start0, m_dst_full,
             m_dst_almost_full, ss_stop0, ss_start1, ss_end1, m_src_last, err_ovf, err_udf},
            {12'b1111_0000_0000});
        chk({tag, ".ocnt"}, ocnt, 0);
    endtask

    task automatic push_dst(input logic [DW-1:0] d, input logic last);
        m_dst_putn = 1'b0; m_dst = d; m_dst_last = last;
        dq.push_back({last, d});
        step();
        m_dst_putn = 1'b1; m_dst_last = 1'b0;
    endtask

    task automatic pop_dst(input string tag);
        e = dq.pop_front();
        chk({tag, ".data"}, wbs_dat_i1, e[DW-1:0]);
        chk({tag, ".end"}, ss_end1, e[DW]);
        ss_xfer1 = 1'b1;
        step();
        ss_xfer1 = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk_reset("rst");
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        step();
        chk_reset("rst_rel");

        // 1: fill src with 0..15, watch flags per count
        for (int i = 0; i < 16; i++) begin
            ss_xfer0 = 1'b1; wbs_dat_o0 = DW'(i); ss_last0 = (i == 15);
            sq.push_back({(i == 15), DW'(i)});
            step();
            chk("t1.empty", m_src_empty, 0);
            chk("t1.stop0", ss_stop0, (i + 1 >= 14));
            chk("t1.ae", m_src_almost_empty, (i + 1 <= 2));
            chk("t1.start0", ss_start0, (i + 1 < 8));
        end
        idle();

        // 2: write on full with simultaneous pop is accepted, without pop is rejected
        ss_xfer0 = 1'b1; wbs_dat_o0 = 16'h0099; m_src_getn = 1'b0;
        e = sq.pop_front();
        chk("t2.head0", {m_src_last, m_src}, e);
        sq.push_back({1'b0, 16'h0099});
        step();
        chk("t2.no_ovf", err_ovf, 0);
        chk("t2.stop0", ss_stop0, 1);
        m_src_getn = 1'b1; wbs_dat_o0 = 16'h0077;
        step();
        chk("t2.ovf", err_ovf, 1);
        idle();
        while (sq.size() != 0) begin
            e = sq.pop_front();
            chk("t2.drain", {m_src_last, m_src}, e);
            m_src_getn = 1'b0;
            step();
        end
        idle();
        chk("t2.empty", m_src_empty, 1);

        // Channel clear drops the sticky error
        m_reset = 1'b1;
        step();
        idle();
        chk("clr.ovf", err_ovf, 0);

        // 3: one 5-beat frame, start1 only once the last beat lands
        for (int k = 1; k <= 5; k++) begin
            push_dst(DW'(16'h100 + k), (k == 5));
            chk("t3.start1", ss_start1, (k == 5));
        end
        chk("t3.ocnt", ocnt, 4);
        for (int k = 1; k <= 5; k++) pop_dst("t3.pop");
        chk("t3.start1_off", ss_start1, 0);
        chk("t3.stop1", ss_stop1, 1);

        // 4: end-of-job flush request, then pop on empty
        push_dst(16'h0200, 1'b0);
        chk("t4.start1_pre", ss_start1, 0);
        m_endn = 1'b0;
        #1;
        chk("t4.start1_endn", ss_start1, 1);
        pop_dst("t4.pop");
        ss_xfer1 = 1'b1;
        step();
        idle();
        chk("t4.udf", err_udf, 1);
        chk("t4.ovf", err_ovf, 0);
        chk("t4.start1", ss_start1, 0);
        chk("t4.stop1", ss_stop1, 1);

        // 5: ocnt saturation with CW=4, plus dst full/almost-full
        m_reset = 1'b1;
        step();
        idle();
        chk("t5.clr_udf", err_udf, 0);
        for (int k = 0; k < 10; k++) push_dst(DW'(16'h300 + k), 1'b0);
        chk("t5.ocnt10", ocnt, 10);
        for (int k = 0; k < 10; k++) pop_dst("t5.pop");
        for (int k = 0; k < 16; k++) begin
            push_dst(DW'(16'h400 + k), 1'b0);
            chk("t5.af", m_dst_almost_full, (k + 1 >= 14));
        end
        chk("t5.full", m_dst_full, 1);
        chk("t5.ocnt_sat", ocnt, 15);
        chk("t5.start1", ss_start1, 1);

        // 6: async reset in the middle of a src burst
        for (int k = 0; k < 3; k++) begin
            ss_xfer0 = 1'b1; wbs_dat_o0 = DW'(k);
            step();
        end
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        chk_reset("t6.async");
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        idle();
        sq.delete();
        dq.delete();
        step();
        chk_reset("t6.async_rel");

        // 6b: m_reset overrides simultaneous push/write
        for (int k = 0; k < 3; k++) begin
            ss_xfer0 = 1'b1; wbs_dat_o0 = DW'(k);
            step();
        end
        push_dst(16'h0500, 1'b0);
        dq.delete();
        m_reset = 1'b1; ss_xfer0 = 1'b1; m_dst_putn = 1'b0; m_dst_last = 1'b1;
        step();
        idle();
        chk_reset("t6.mreset");
        ss_xfer0 = 1'b1; wbs_dat_o0 = 16'h0abc;
        step();
        idle();
        chk("t6.reuse", m_src, 16'h0abc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
